pe_seq_ctrl: RTL and testbench

//  Sequencer for pe_array. Accepts one vector command (instr, alg, two source bases,

---
 rtl/pe_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq_ctrl
// Description : Command sequencer for pe_array. Accepts one vector command
//               (opcode, parameter set, two source bases, destination base,
//               beat count), streams one pair of read addresses per beat to
//               the coefficient RAM, holds opcode/parameter set/modulus
//               steady on the PE, and issues each write-back exactly
//               RD_LAT+PE_LAT cycles after its read. done pulses with the
//               final write-back; done+err pulse together for an illegal
//               command.
// Ports       : clk, rst (sync, active-high)
//               cmd_valid/cmd_ready handshake; cmd_instr, cmd_alg,
//               cmd_src0, cmd_src1, cmd_dst, cmd_len (beats-1)
//               hold        : stall issue this cycle
//               rd_en, rd_addr0, rd_addr1 : RAM read port
//               pe_instr, pe_alg, q_out   : static PE configuration
//               wr_en, wr_addr            : result write port
//               busy, done, err           : status
// Revision    : 1.0 - initial release
// ============================================================================
module pe_seq_ctrl #(
    parameter int NUM    = 4,
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_instr,
    input  logic [4:0]        cmd_alg,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [4:0]        pe_instr,
    output logic [4:0]        pe_alg,
    output logic [WIDTH-1:0]  q_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                c_DEPTH     = RD_LAT + PE_LAT;
    localparam logic [WIDTH-1:0]  c_Q_KYBER   = WIDTH'(3329);
    localparam logic [WIDTH-1:0]  c_Q_DIL     = WIDTH'(8380417);
    // Every pipe stage except the output stage; any of these set means more
    // write-backs are still coming after the current one.
    localparam logic [c_DEPTH-1:0] c_HEAD_MASK = {c_DEPTH{1'b1}} >> 1;

    // Elaboration-time sanity check on the parameter set.
    if (NUM < 1 || c_DEPTH < 1) begin : g_bad_param
        $error("pe_seq_ctrl: NUM and RD_LAT+PE_LAT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_src0;
    logic [ADDR_W-1:0]  r_src1;
    logic [ADDR_W-1:0]  r_dst;
    logic [ADDR_W-1:0]  r_len;
    // One bit wider than the address so a full 2^ADDR_W-beat command counts
    // through without aliasing back to zero.
    logic [ADDR_W:0]    r_cnt;

    logic [4:0]         r_pe_instr;
    logic [4:0]         r_pe_alg;
    logic [WIDTH-1:0]   r_q;

    logic [c_DEPTH-1:0] r_pipe_v;
    logic [ADDR_W-1:0]  r_pipe_a [c_DEPTH];

    logic               w_accept;
    logic               w_legal;
    logic               w_rd_en;
    logic               w_cnt_last;
    logic               w_more;
    logic               w_final_wr;
    logic [ADDR_W-1:0]  w_beat;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_legal    = (cmd_alg <= 5'd5) && (cmd_instr <= 5'd25);
    assign w_rd_en    = (r_state == S_ISSUE) && !hold;
    assign w_cnt_last = (r_cnt == {1'b0, r_len});
    assign w_beat     = r_cnt[ADDR_W-1:0];
    assign w_more     = |(r_pipe_v & c_HEAD_MASK);
    // In DRAIN no new reads enter the pipe, so the write leaving the tail
    // with nothing behind it is the last one of the command.
    assign w_final_wr = (r_state == S_DRAIN) && r_pipe_v[c_DEPTH-1] && !w_more;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_legal ? S_ISSUE : S_ERR;
                end
            end
            S_ISSUE: begin
                if (w_rd_en && w_cnt_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_final_wr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, beat counter and PE configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src0     <= '0;
            r_src1     <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_pe_instr <= 5'd0;
            r_pe_alg   <= 5'd0;
            r_q        <= c_Q_KYBER;
        end else begin
            if (w_accept) begin
                r_src0 <= cmd_src0;
                r_src1 <= cmd_src1;
                r_dst  <= cmd_dst;
                r_len  <= cmd_len;
                r_cnt  <= '0;
                // An illegal command leaves the PE configuration untouched.
                if (w_legal) begin
                    r_pe_instr <= cmd_instr;
                    r_pe_alg   <= cmd_alg;
                    r_q        <= (cmd_alg <= 5'd2) ? c_Q_KYBER : c_Q_DIL;
                end
            end else if (w_rd_en) begin
                r_cnt <= r_cnt + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-back delay line: one {valid, address} entry per cycle so hold
    // gaps on the read side reappear as identical gaps on the write side.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pipe_a[i] <= '0;
            end
        end else begin
            r_pipe_v[0] <= w_rd_en;
            r_pipe_a[0] <= r_dst + w_beat;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_a[i] <= r_pipe_a[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rd_en     = w_rd_en;
    assign rd_addr0  = r_src0 + w_beat;
    assign rd_addr1  = r_src1 + w_beat;
    assign wr_en     = r_pipe_v[c_DEPTH-1];
    assign wr_addr   = r_pipe_a[c_DEPTH-1];
    assign done      = w_final_wr || (r_state == S_ERR);
    assign err       = (r_state == S_ERR);
    assign pe_instr  = r_pe_instr;
    assign pe_alg    = r_pe_alg;
    assign q_out     = r_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_seq_ctrl
// Description : Self-checking bench for pe_seq_ctrl. Directed command table,
//               reset / abort sequences and random commands, all compared
//               cycle by cycle against a beat-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_seq_ctrl;

    localparam int c_LAT  = 2;    // RAM read latency + PE latency
    localparam int c_MAXT = 600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_instr = '0;
    logic [4:0] cmd_alg = '0;
    logic [7:0] cmd_src0 = '0;
    logic [7:0] cmd_src1 = '0;
    logic [7:0] cmd_dst = '0;
    logic [7:0] cmd_len = '0;
    logic       hold = 1'b0;
    logic       rd_en;
    logic [7:0] rd_addr0;
    logic [7:0] rd_addr1;
    logic [4:0] pe_instr;
    logic [4:0] pe_alg;
    logic [31:0] q_out;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic       busy;
    logic       done;
    logic       err;

    pe_seq_ctrl #(
        .NUM(4), .ADDR_W(8), .WIDTH(32), .RD_LAT(1), .PE_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_alg(cmd_alg),
        .cmd_src0(cmd_src0), .cmd_src1(cmd_src1),
        .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .hold(hold),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .pe_instr(pe_instr), .pe_alg(pe_alg), .q_out(q_out),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  instr;
        logic [4:0]  alg;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [7:0]  dst;
        logic [7:0]  len;
        logic [31:0] hmask;   // bit i-1 = hold in cycle i after accept
        bit          keep;    // keep cmd_valid high while busy
        logic [31:0] exp_q;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    // Reference model: expected activity per cycle after accept.
    bit         m_rd [c_MAXT];
    logic [7:0] m_a0 [c_MAXT];
    logic [7:0] m_a1 [c_MAXT];
    bit         m_wr [c_MAXT];
    logic [7:0] m_wa [c_MAXT];
    logic [4:0]  cur_instr = 5'd0;
    logic [4:0]  cur_alg   = 5'd0;
    logic [31:0] cur_q     = 32'd3329;

    function automatic vec_t mk(input logic [4:0] instr, input logic [4:0] alg,
                                input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] dst, input logic [7:0] len,
                                input logic [31:0] hmask, input bit keep,
                                input logic [31:0] exp_q, input bit exp_err);
        vec_t v;
        v.instr = instr; v.alg = alg; v.s0 = s0; v.s1 = s1; v.dst = dst;
        v.len = len; v.hmask = hmask; v.keep = keep; v.exp_q = exp_q;
        v.exp_err = exp_err;
        return v;
    endfunction

    function automatic bit hbit(input logic [31:0] m, input int t);
        if (t >= 1 && t <= 32) return m[t-1];
        return 1'b0;
    endfunction

    function automatic logic [71:0] pk(input logic rde, input logic [7:0] a0,
                                       input logic [7:0] a1, input logic wre,
                                       input logic [7:0] wa, input logic dn,
                                       input logic er, input logic bs,
                                       input logic rdy, input logic [4:0] pi,
                                       input logic [4:0] pa, input logic [31:0] q);
        return {rde, rde ? a0 : 8'h00, rde ? a1 : 8'h00, wre, wre ? wa : 8'h00,
                dn, er, bs, rdy, pi, pa, q};
    endfunction

    function automatic logic [71:0] act_vec();
        return pk(rd_en, rd_addr0, rd_addr1, wr_en, wr_addr, done, err, busy,
                  cmd_ready, pe_instr, pe_alg, q_out);
    endfunction

    task automatic check(input string name, input int t,
                         input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    // Drive one command, compute its expected trace from the beat rules and
    // compare every cycle until two cycles after done.
    task automatic run_cmd(input string name, input vec_t v, input bit use_exp);
        int  done_t;
        int  beat;
        int  t;
        bit  illegal;
        for (int i = 0; i < c_MAXT; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0;
            m_a0[i] = '0; m_a1[i] = '0; m_wa[i] = '0;
        end
        illegal = (v.alg > 5'd5) || (v.instr > 5'd25);
        done_t  = 1;
        if (!illegal) begin
            beat = 0;
            t    = 1;
            while (beat <= int'(v.len)) begin
                if (!hbit(v.hmask, t)) begin
                    m_rd[t] = 1'b1;
                    m_a0[t] = 8'(int'(v.s0) + beat);
                    m_a1[t] = 8'(int'(v.s1) + beat);
                    m_wr[t+c_LAT] = 1'b1;
                    m_wa[t+c_LAT] = 8'(int'(v.dst) + beat);
                    done_t = t + c_LAT;
                    beat++;
                end
                t++;
            end
            cur_instr = v.instr;
            cur_alg   = v.alg;
            cur_q     = (v.alg <= 5'd2) ? 32'd3329 : 32'd8380417;
        end

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_instr = v.instr; cmd_alg = v.alg;
        cmd_src0 = v.s0; cmd_src1 = v.s1; cmd_dst = v.dst; cmd_len = v.len;
        hold = 1'b0;
        @(negedge clk);
        check({name, "_ready"}, 0, {71'b0, cmd_ready}, {71'b0, 1'b1});
        for (int tt = 1; tt <= done_t + 2; tt++) begin
            @(posedge clk); #1;
            cmd_valid = v.keep && (tt < done_t);
            hold      = hbit(v.hmask, tt);
            @(negedge clk);
            check(name, tt, act_vec(),
                  pk(m_rd[tt], m_a0[tt], m_a1[tt], m_wr[tt], m_wa[tt],
                     tt == done_t, illegal && tt == 1, tt <= done_t, tt > done_t,
                     cur_instr, cur_alg, cur_q));
            if (tt == 1 && use_exp) begin
                check({name, "_err"}, tt, {71'b0, err}, {71'b0, v.exp_err});
                if (!v.exp_err)
                    check({name, "_q"}, tt, {40'b0, q_out}, {40'b0, v.exp_q});
            end
        end
        cmd_valid = 1'b0;
        hold      = 1'b0;
    endtask

    initial begin
        vec_t rv;

        // Directed table
        vecs[0] = mk(5'd0,  5'd0,  8'h10, 8'h20, 8'h30, 8'd3,   32'h0,         1'b0, 32'd3329,    1'b0);
        vecs[1] = mk(5'd3,  5'd4,  8'hFE, 8'h40, 8'hFD, 8'd3,   32'h0,         1'b0, 32'd8380417, 1'b0);
        vecs[2] = mk(5'd1,  5'd1,  8'h50, 8'h60, 8'h70, 8'd2,   32'h2,         1'b0, 32'd3329,    1'b0);
        vecs[3] = mk(5'd2,  5'd7,  8'h11, 8'h22, 8'h33, 8'd5,   32'h0,         1'b1, 32'd0,       1'b1);
        vecs[4] = mk(5'd26, 5'd0,  8'h01, 8'h02, 8'h03, 8'd1,   32'h0,         1'b0, 32'd0,       1'b1);
        vecs[5] = mk(5'd25, 5'd5,  8'hA0, 8'hB0, 8'hC0, 8'd0,   32'h0,         1'b1, 32'd8380417, 1'b0);
        vecs[6] = mk(5'd0,  5'd2,  8'h05, 8'h06, 8'h07, 8'd0,   32'h5,         1'b0, 32'd3329,    1'b0);
        vecs[7] = mk(5'd7,  5'd3,  8'h80, 8'h81, 8'h7F, 8'd255, 32'hF0F0_0003, 1'b0, 32'd8380417, 1'b0);
        vecs[8] = mk(5'd4,  5'd6,  8'h00, 8'h00, 8'h00, 8'd2,   32'h0,         1'b0, 32'd0,       1'b1);
        vecs[9] = mk(5'd31, 5'd31, 8'hFF, 8'hFF, 8'hFF, 8'd9,   32'h0,         1'b1, 32'd0,       1'b1);

        // Reset
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_reset", 0, {68'b0, rd_en, wr_en, busy, done},
              {68'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", 0, act_vec(),
              pk(1'b0, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1,
                 5'd0, 5'd0, 32'd3329));
        check("reset_addr", 0, {48'b0, rd_addr0, rd_addr1, wr_addr}, 72'h0);

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

        // Abort a long command mid-ISSUE with reset
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_instr = 5'd4; cmd_alg = 5'd3;
        cmd_src0 = 8'h10; cmd_src1 = 8'h20; cmd_dst = 8'h30; cmd_len = 8'd255;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort_pre", 0, {69'b0, rd_en, busy, wr_en}, {69'b0, 1'b1, 1'b1, 1'b1});
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        cur_instr = 5'd0; cur_alg = 5'd0; cur_q = 32'd3329;
        check("abort_post", 0, act_vec(),
              pk(1'b0, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1,
                 5'd0, 5'd0, 32'd3329));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("abort_quiet", i, {68'b0, rd_en, wr_en, done, busy}, 72'h0);
        end
        run_cmd("after_abort", vecs[0], 1'b1);

        // Random commands
        for (int i = 0; i < 30; i++) begin
            rv.instr = 5'($urandom_range(0, 27));
            rv.alg   = 5'($urandom_range(0, 7));
            rv.s0    = 8'($urandom);
            rv.s1    = 8'($urandom);
            rv.dst   = 8'($urandom);
            rv.len   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 12));
            rv.hmask = $urandom & $urandom;
            rv.keep  = 1'($urandom_range(0, 1));
            rv.exp_q = 32'd0;
            rv.exp_err = 1'b0;
            run_cmd($sformatf("rnd%0d", i), rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
